// File: rtl/overture_pkg.sv
// Shared Overture core types: opcode classes, condition codes, fetch sequencer states.
// Types only; no latency or backpressure of its own.
// Imported by overture_fetch_branch.
package overture_pkg;

  typedef enum logic [1:0] {
    OP_IMM  = 2'b00,
    OP_CALC = 2'b01,
    OP_COPY = 2'b10,
    OP_COND = 2'b11
  } op_class_e;

  typedef enum logic [2:0] {
    COND_NEVER      = 3'b000,
    COND_EQUAL      = 3'b001,
    COND_LESS       = 3'b010,
    COND_LESS_EQ    = 3'b011,
    COND_ALWAYS     = 3'b100,
    COND_NOT_EQ     = 3'b101,
    COND_GREATER_EQ = 3'b110,
    COND_GREATER    = 3'b111
  } cond_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    FETCH  = 2'b01,
    ISSUE  = 2'b10,
    BRANCH = 2'b11
  } fetch_state_e;

  function automatic logic is_cond_op(input logic [7:0] op);
    return op_class_e'(op[7:6]) == OP_COND;
  endfunction

endpackage

// File: rtl/overture_fetch_branch.sv
// Overture fetch/PC sequencer; optional taken-branch counter under `OVERTURE_BRANCH_STATS_EN.
// Latency: non-branch = fetch wait + 1 ISSUE cycle, branch = fetch wait + 1 BRANCH cycle (min 2).
// Backpressure: imem_req held until imem_valid; instr held in ISSUE until exec_ready.
module overture_fetch_branch
  import overture_pkg::*;
#(
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [7:0]      imem_data,
  output logic [7:0]      instr,
  output logic            instr_valid,
  input  logic            exec_ready,
  output logic [2:0]      cond_sel,
  input  logic            cond_met,
  input  logic [PC_W-1:0] r0,
  output logic [PC_W-1:0] pc,
  output logic            busy
`ifdef OVERTURE_BRANCH_STATS_EN
  ,
  output logic [15:0]     taken_count
`endif
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      instr_q, instr_d;
  logic [2:0]      cond_sel_q, cond_sel_d;
  logic [PC_W-1:0] pc_inc;

  assign pc_inc = pc_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    cond_sel_d = cond_sel_q;
    case (state_q)
      IDLE: begin
        if (run) state_d = FETCH;
      end
      FETCH: begin
        if (imem_valid) begin
          instr_d = imem_data;
          if (is_cond_op(imem_data)) begin
            cond_sel_d = imem_data[2:0];
            state_d    = BRANCH;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (exec_ready) begin
          pc_d    = pc_inc;
          state_d = run ? FETCH : IDLE;
        end
      end
      BRANCH: begin
        // r0 and cond_met are only trusted here; the single-outstanding execute stage has settled them.
        pc_d    = cond_met ? r0 : pc_inc;
        state_d = run ? FETCH : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      cond_sel_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      cond_sel_q <= cond_sel_d;
    end
  end

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == ISSUE);
  assign cond_sel    = cond_sel_q;
  assign pc          = pc_q;
  assign busy        = (state_q != IDLE);

`ifdef OVERTURE_BRANCH_STATS_EN
  logic [15:0] taken_count_q, taken_count_d;

  always_comb begin
    taken_count_d = taken_count_q;
    if (state_q == BRANCH && cond_met && taken_count_q != 16'hFFFF) begin
      taken_count_d = taken_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) taken_count_q <= '0;
    else     taken_count_q <= taken_count_d;
  end

  assign taken_count = taken_count_q;
`endif

endmodule
